and_unit_arbiter: RTL and testbench



---
 rtl/and_unit_arbiter_pkg.sv | 12 +
 rtl/and_unit_arbiter_if.sv | 29 ++
 rtl/and_unit_arbiter_rr_priority_picker.sv | 33 +++
 rtl/and_unit_arbiter.sv | 94 +++++++++
 tb/tb_and_unit_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/and_unit_arbiter_pkg.sv
// Shared constants and types for the round-robin AND-unit arbiter and its requester blocks.
package and_unit_arbiter_pkg;

  localparam int unsigned NReqDefault  = 4;
  localparam int unsigned WidthDefault = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StResp = 1'b1
  } state_e;

endpackage

// File: rtl/and_unit_arbiter_if.sv
// Request/operand/result bundle between requesters, the arbiter and the result consumer.
interface and_unit_arbiter_if
  import and_unit_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  parameter int unsigned WIDTH = WidthDefault
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] op_a;
  logic [N_REQ*WIDTH-1:0] op_b;
  logic [N_REQ-1:0]       gnt;
  logic                   res_valid;
  logic [WIDTH-1:0]       res_data;
  logic [ID_W-1:0]        res_id;
  logic                   res_ready;

  modport slave (
    input  req, op_a, op_b, res_ready,
    output gnt, res_valid, res_data, res_id
  );

  modport master (
    output req, op_a, op_b, res_ready,
    input  gnt, res_valid, res_data, res_id
  );

endinterface

// File: rtl/and_unit_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping past N_REQ-1.
module rr_priority_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             any_req_o,
  output logic [ID_W-1:0]  win_idx_o,
  output logic [N_REQ-1:0] win_onehot_o
);

  logic        found;
  int unsigned idx;

  always_comb begin
    any_req_o    = |req_i;
    win_idx_o    = '0;
    win_onehot_o = '0;
    found        = 1'b0;
    idx          = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_i[idx]) begin
        found             = 1'b1;
        win_idx_o         = ID_W'(idx);
        win_onehot_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/and_unit_arbiter.sv
// Shares one registered AND unit among N_REQ requesters; result is held until the consumer
// accepts it, after which the round-robin pointer moves past the served requester.
module and_unit_arbiter
  import and_unit_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  parameter int unsigned WIDTH = WidthDefault
) (
  input logic               clk,
  input logic               rst_n,
  and_unit_arbiter_if.slave bus
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;

  logic             any_req;
  logic [ID_W-1:0]  win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [WIDTH-1:0] sel_a, sel_b;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req_i        (bus.req),
    .ptr_i        (rr_ptr_q),
    .any_req_o    (any_req),
    .win_idx_o    (win_idx),
    .win_onehot_o (win_onehot)
  );

  assign sel_a = bus.op_a[win_idx*WIDTH +: WIDTH];
  assign sel_b = bus.op_b[win_idx*WIDTH +: WIDTH];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = '0;  // grant is a single-cycle pulse
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          res_data_d  = sel_a & sel_b;
          res_id_d    = win_idx;
          gnt_d       = win_onehot;
          res_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        // requests are ignored here; only the consumer handshake matters
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = (res_id_q == ID_W'(N_REQ - 1)) ? '0 : res_id_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed bench for and_unit_arbiter with a scoreboard of expected (id, data) results.
module tb_and_unit_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];
  logic [7:0] a_v[N_REQ];
  logic [7:0] b_v[N_REQ];

  and_unit_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  and_unit_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    a_v[i] = a;
    b_v[i] = b;
    bus.op_a[i*WIDTH +: WIDTH] = a;
    bus.op_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id   = 2'(id);
    e.data = a_v[id] & b_v[id];
    sb.push_back(e);
  endtask

  // Waits (bounded) for res_valid, checks it against the scoreboard head, steps one cycle.
  task automatic wait_result(input string tag, output int seen_cyc);
    exp_t e;
    int   n;
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    seen_cyc = cyc;
    if (bus.res_valid !== 1'b1) begin
      chk({tag, "_timeout"}, 32'(bus.res_valid), 32'd1);
    end else if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_id"}, 32'(bus.res_id), 32'(e.id));
      chk({tag, "_data"}, 32'(bus.res_data), 32'(e.data));
      chk({tag, "_gnt"}, 32'(bus.gnt), 32'(4'b0001 << e.id));
    end
    step();
  endtask

  initial begin
    int t_prev, t_now;
    rst_n         = 1'b0;
    bus.req       = 4'b1111;
    bus.res_ready = 1'b1;
    bus.op_a      = '0;
    bus.op_b      = '0;
    for (int i = 0; i < N_REQ; i++) set_op(i, 8'($urandom), 8'($urandom));

    // Reset with all requests high
    step();
    step();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_data", 32'(bus.res_data), 32'd0);
    chk("rst_id", 32'(bus.res_id), 32'd0);

    // Round-robin with all requesting: 0,1,2,3,0 every second cycle
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) push_exp(k % N_REQ);
    wait_result("rr0", t_prev);
    for (int k = 1; k < 5; k++) begin
      wait_result($sformatf("rr%0d", k), t_now);
      chk($sformatf("rr%0d_spacing", k), 32'(t_now - t_prev), 32'd2);
      t_prev = t_now;
    end
    bus.req = 4'b0000;
    step();
    chk("idle_no_valid", 32'(bus.res_valid), 32'd0);

    // Single request from requester 2
    set_op(2, 8'hF0, 8'h3C);
    bus.req = 4'b0100;
    step();
    chk("single_valid", 32'(bus.res_valid), 32'd1);
    chk("single_gnt", 32'(bus.gnt), 32'b0100);
    chk("single_data", 32'(bus.res_data), 32'h30);
    chk("single_id", 32'(bus.res_id), 32'd2);
    bus.req = 4'b0000;
    step();
    chk("single_back_idle", 32'(bus.res_valid), 32'd0);
    chk("single_gnt_low", 32'(bus.gnt), 32'd0);

    // Backpressure: pointer is at 3, so requester 3 wins first
    bus.req       = 4'b1010;
    bus.res_ready = 1'b0;
    push_exp(3);
    step();
    chk("bp_valid0", 32'(bus.res_valid), 32'd1);
    chk("bp_gnt0", 32'(bus.gnt), 32'b1000);
    chk("bp_id0", 32'(bus.res_id), 32'd3);
    chk("bp_data0", 32'(bus.res_data), 32'(a_v[3] & b_v[3]));
    void'(sb.pop_front());
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("bp_valid%0d", k), 32'(bus.res_valid), 32'd1);
      chk($sformatf("bp_gnt%0d", k), 32'(bus.gnt), 32'd0);
      chk($sformatf("bp_id%0d", k), 32'(bus.res_id), 32'd3);
      chk($sformatf("bp_data%0d", k), 32'(bus.res_data), 32'(a_v[3] & b_v[3]));
    end
    bus.res_ready = 1'b1;
    push_exp(1);
    step();
    chk("bp_release", 32'(bus.res_valid), 32'd0);
    wait_result("bp_next", t_now);
    bus.req = 4'b0000;

    // Wrap: serve 3, then 0 and 1
    bus.req = 4'b1000;
    push_exp(3);
    wait_result("wrap3", t_now);
    bus.req = 4'b0011;
    push_exp(0);
    push_exp(1);
    wait_result("wrap0", t_now);
    wait_result("wrap1", t_now);
    bus.req = 4'b0000;

    // Reset during RESP discards the pending result and clears the pointer
    bus.req       = 4'b0100;
    bus.res_ready = 1'b0;
    step();
    chk("mid_valid_pre", 32'(bus.res_valid), 32'd1);
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    step();
    chk("mid_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_data", 32'(bus.res_data), 32'd0);
    chk("mid_id", 32'(bus.res_id), 32'd0);
    rst_n         = 1'b1;
    bus.res_ready = 1'b1;
    step();
    chk("mid_no_replay", 32'(bus.res_valid), 32'd0);
    bus.req = 4'b1111;
    push_exp(0);
    wait_result("mid_ptr0", t_now);
    bus.req = 4'b0000;
    step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
